// File: rtl/mmio_bridge.sv
// mmio_bridge: data-port address decode, MMIO registers and dot FIFO
// between the core, data RAM, RNG, generation counter and VGA path.
module mmio_bridge #(
    parameter int          DOT_COUNT  = 450,
    parameter int          X_BASE     = 100,
    parameter int          Y_BASE     = 550,
    parameter int          RNG_ADDR   = 99,
    parameter int          GEN_ADDR   = 98,
    parameter int          STAT_ADDR  = 97,
    parameter int          FIFO_DEPTH = 16,
    parameter int          ID_W       = 10,
    parameter int          LOC_W      = 32,
    parameter int          GEN_W      = 14,
    parameter int          GEN_MAX    = 9999,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic             cpu_wren,
    output logic [31:0]      cpu_rdata,
    input  logic             inc_gen,
    output logic [11:0]      ram_addr,
    output logic [31:0]      ram_wdata,
    output logic             ram_wren,
    input  logic [31:0]      ram_rdata,
    output logic             dot_valid,
    input  logic             dot_ready,
    output logic             dot_is_y,
    output logic [ID_W-1:0]  dot_id,
    output logic [LOC_W-1:0] dot_loc,
    output logic [GEN_W-1:0] gen_count,
    output logic             fifo_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [GEN_W-1:0] GEN_MAX_C = GEN_W'(GEN_MAX);

    typedef enum logic [2:0] {
        CL_RAM, CL_RNG, CL_GEN, CL_STAT, CL_X, CL_Y
    } cls_t;

    typedef struct packed {
        logic             is_y;
        logic [ID_W-1:0]  id;
        logic [LOC_W-1:0] loc;
    } dot_t;

    cls_t cls;
    cls_t cls_q;
    logic in_x;
    logic in_y;

    assign in_x = (cpu_addr >= 32'(X_BASE)) &&
                  (cpu_addr < 32'(X_BASE + DOT_COUNT));
    assign in_y = (cpu_addr >= 32'(Y_BASE)) &&
                  (cpu_addr < 32'(Y_BASE + DOT_COUNT));

    always_comb begin
        if (cpu_addr == 32'(RNG_ADDR))       cls = CL_RNG;
        else if (cpu_addr == 32'(GEN_ADDR))  cls = CL_GEN;
        else if (cpu_addr == 32'(STAT_ADDR)) cls = CL_STAT;
        else if (in_x)                       cls = CL_X;
        else if (in_y)                       cls = CL_Y;
        else                                 cls = CL_RAM;
    end

    assign ram_addr  = cpu_addr[11:0];
    assign ram_wdata = cpu_wdata;
    assign ram_wren  = cpu_wren && (cls == CL_RAM) &&
                       (cpu_addr < 32'd4096);

    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [31:0] rng_q;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);

    logic [GEN_W-1:0] gen_wr;
    logic [GEN_W-1:0] gen_next;

    assign gen_wr = cpu_wdata[GEN_W-1:0];

    // A CPU load beats a same-cycle increment pulse
    always_comb begin
        gen_next = gen_count;
        if (cpu_wren && cls == CL_GEN)
            gen_next = (gen_wr > GEN_MAX_C) ? GEN_MAX_C : gen_wr;
        else if (inc_gen)
            gen_next = (gen_count == GEN_MAX_C) ? '0
                                                : gen_count + GEN_W'(1);
    end

    dot_t          mem [FIFO_DEPTH];
    dot_t          head;
    dot_t          push_dot;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [31:0]   base;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          stat_clr;

    assign base     = (cls == CL_Y) ? 32'(Y_BASE) : 32'(X_BASE);
    assign push_dot = '{is_y: (cls == CL_Y),
                        id:   ID_W'(cpu_addr - base),
                        loc:  cpu_wdata[LOC_W-1:0]};

    assign dot_valid = (count != '0);
    assign pop       = dot_valid && dot_ready;
    assign push_req  = cpu_wren && (cls == CL_X || cls == CL_Y);
    // A full FIFO still takes a push when the head leaves this cycle
    assign push_ok   = push_req && ((count < DEPTH_C) || pop);
    assign stat_clr  = cpu_wren && (cls == CL_STAT) && cpu_wdata[31];

    assign head     = mem[rptr];
    assign dot_is_y = dot_valid && head.is_y;
    assign dot_id   = dot_valid ? head.id : '0;
    assign dot_loc  = dot_valid ? head.loc : '0;

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wptr] <= push_dot;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            fifo_overflow <= 1'b0;
            gen_count     <= '0;
            lfsr          <= SEED_EFF;
            rng_q         <= '0;
            cls_q         <= CL_RAM;
        end else begin
            if (push_ok)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);
            fifo_overflow <= (push_req && !push_ok) ||
                             (fifo_overflow && !stat_clr);
            gen_count <= gen_next;
            lfsr      <= lfsr_next;
            rng_q     <= lfsr;
            cls_q     <= cls;
        end
    end

    logic [31:0] status;

    assign status = 32'({fifo_overflow, count});

    always_comb begin
        case (cls_q)
            CL_RNG:  cpu_rdata = rng_q;
            CL_GEN:  cpu_rdata = 32'(gen_count);
            CL_STAT: cpu_rdata = status;
            CL_RAM:  cpu_rdata = ram_rdata;
            default: cpu_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed and random stimulus against a transaction
// model; a negedge monitor pops read and dot scoreboards.
module tb_mmio_bridge;
    localparam int DC    = 450;
    localparam int XB    = 100;
    localparam int YB    = 550;
    localparam int RA    = 99;
    localparam int GA    = 98;
    localparam int SA    = 97;
    localparam int DEPTH = 16;
    localparam int GMAX  = 9999;
    localparam logic [31:0] MASK = 32'h8020_0003;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_wren = 1'b0;
    logic        inc_gen = 1'b0;
    logic        dot_ready = 1'b0;
    logic [31:0] cpu_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_rdata = '0;
    logic        dot_valid;
    logic        dot_is_y;
    logic [9:0]  dot_id;
    logic [31:0] dot_loc;
    logic [13:0] gen_count;
    logic        fifo_overflow;

    mmio_bridge #(.SEED(32'd1)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata),
        .inc_gen(inc_gen),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wren(ram_wren), .ram_rdata(ram_rdata),
        .dot_valid(dot_valid), .dot_ready(dot_ready),
        .dot_is_y(dot_is_y), .dot_id(dot_id), .dot_loc(dot_loc),
        .gen_count(gen_count), .fifo_overflow(fifo_overflow)
    );

    always #5 clock = ~clock;

    logic [31:0] ram_mem [4096];
    always @(posedge clock) begin
        if (ram_wren)
            ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    typedef struct {
        bit        is_y;
        bit [9:0]  id;
        bit [31:0] loc;
    } dot_e;

    dot_e        exp_dots[$];
    logic [31:0] rd_exp[$];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    int          m_gen = 0;
    bit   [31:0] m_lfsr = 32'd1;
    bit   [31:0] m_ram [4096];
    bit          rd_req = 1'b0;
    bit          rd_chk = 1'b0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clock) rd_chk <= rd_req;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int class_of(input logic [31:0] a);
        if (a == RA) return 1;
        if (a == GA) return 2;
        if (a == SA) return 3;
        if (a >= XB && a < XB + DC) return 4;
        if (a >= YB && a < YB + DC) return 5;
        return 0;
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] wd,
                        input bit we, input bit inc, input bit rdy,
                        input bit rd);
        int          c;
        int          v;
        logic [31:0] e;
        bit          pop;
        bit          set_ovf;
        dot_e        d;
        cpu_addr = a; cpu_wdata = wd; cpu_wren = we;
        inc_gen = inc; dot_ready = rdy; rd_req = rd;
        @(posedge clock);
        c = class_of(a);
        e = '0;
        if (c == 1) e = m_lfsr;
        else if (c == 0) e = m_ram[a[11:0]];
        pop = (m_cnt > 0) && rdy;
        set_ovf = 1'b0;
        if (we && (c == 4 || c == 5)) begin
            if (m_cnt < DEPTH || pop) begin
                d.is_y = (c == 5);
                d.id = 10'(a - 32'((c == 5) ? YB : XB));
                d.loc = wd;
                exp_dots.push_back(d);
                m_cnt++;
            end else begin
                set_ovf = 1'b1;
            end
        end
        if (pop) m_cnt--;
        if (we && c == 3 && wd[31]) m_ovf = 1'b0;
        if (set_ovf) m_ovf = 1'b1;
        if (we && c == 2) begin
            v = int'(wd[13:0]);
            m_gen = (v > GMAX) ? GMAX : v;
        end else if (inc) begin
            m_gen = (m_gen == GMAX) ? 0 : m_gen + 1;
        end
        if (we && c == 0 && a < 4096) m_ram[a[11:0]] = wd;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? MASK : 32'd0);
        if (c == 2) e = 32'(m_gen);
        if (c == 3) e = 32'(m_cnt) | (32'(m_ovf) << 5);
        if (rd) rd_exp.push_back(e);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(32'd0, 32'd0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cpu_wren = 1'b0; inc_gen = 1'b0; dot_ready = 1'b0;
        rd_req = 1'b0; reset = 1'b1;
        @(posedge clock);
        exp_dots.delete(); rd_exp.delete();
        m_cnt = 0; m_ovf = 1'b0; m_gen = 0; m_lfsr = 32'd1;
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("ram_wren", 32'(ram_wren),
                32'(cpu_wren && class_of(cpu_addr) == 0 && cpu_addr < 4096));
            chk("gen_count", 32'(gen_count), 32'(m_gen));
            chk("overflow", 32'(fifo_overflow), 32'(m_ovf));
            if (rd_chk) begin
                if (rd_exp.size() == 0)
                    chk("rd_queue", 32'd0, 32'd1);
                else
                    chk("rdata", cpu_rdata, rd_exp.pop_front());
            end
            if (exp_dots.size() > 0) begin
                chk("dot_valid", 32'(dot_valid), 32'd1);
                chk("dot_is_y", 32'(dot_is_y), 32'(exp_dots[0].is_y));
                chk("dot_id", 32'(dot_id), 32'(exp_dots[0].id));
                chk("dot_loc", dot_loc, exp_dots[0].loc);
                if (dot_ready)
                    void'(exp_dots.pop_front());
            end else begin
                chk("dot_valid", 32'(dot_valid), 32'd0);
            end
        end
    end

    initial begin
        int          sel;
        logic [31:0] a;
        logic [31:0] wd;
        bit          rdy;
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            m_ram[i] = '0;
        end
        idle(1'b0);
        do_reset();

        step(RA, 0, 0, 0, 0, 1);
        step(RA, 0, 0, 0, 0, 1);

        step(100, 450, 1, 0, 0, 0);
        step(551, 200, 1, 0, 0, 0);
        step(SA, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        for (int i = 0; i < 17; i++) step(XB + i, 1000 + i, 1, 0, 0, 0);
        step(SA, 0, 0, 0, 0, 1);
        step(SA, 32'h8000_0000, 1, 0, 0, 1);
        step(YB + 7, 77, 1, 0, 1, 0);
        step(SA, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) idle(1'b1);

        step(GA, GMAX, 1, 0, 0, 1);
        step(GA, 0, 0, 1, 0, 1);
        step(GA, 5, 1, 1, 0, 1);
        step(GA, 32'h3FFF, 1, 0, 0, 0);
        step(GA, 0, 0, 0, 0, 1);

        step(40, 32'hDEAD, 1, 0, 0, 0);
        step(40, 0, 0, 0, 0, 1);
        step(100, 32'h1234, 1, 0, 0, 0);
        step(4096 + 40, 32'hBEEF, 1, 0, 0, 0);
        step(40, 0, 0, 0, 1, 1);
        idle(1'b1);

        for (int i = 0; i < 3; i++) step(YB + i, i, 1, 0, 0, 0);
        step(GA, 42, 1, 0, 0, 0);
        do_reset();
        step(SA, 0, 0, 0, 0, 1);
        step(GA, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = RA;
                1: a = GA;
                2: a = SA;
                3, 4: a = XB + $urandom_range(0, DC - 1);
                5, 6: a = YB + $urandom_range(0, DC - 1);
                7: a = $urandom_range(0, 96);
                8: a = $urandom_range(1000, 4095);
                default: a = $urandom_range(4096, 8191);
            endcase
            wd = $urandom;
            if ((i / 300) % 2 == 1)
                rdy = ($urandom_range(0, 5) == 0);
            else
                rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step(a, wd, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), rdy, 1'b1);
        end

        for (int i = 0; i < 20; i++) idle(1'b1);
        chk("drained", 32'(exp_dots.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
